// File: rtl/cpu_wb_pkg.sv
// Shared types and sizing for the CPU writeback scheduler.
package cpu_wb_pkg;

   localparam int unsigned NUM_REGS         = 8;
   localparam int unsigned REG_WIDTH        = 32;
   localparam int unsigned REG_IDX_W        = 3;
   localparam int unsigned MAX_MUL_INFLIGHT = 4;
   localparam int unsigned SB_WIDTH         = NUM_REGS;

   // Bits needed to hold a count from 0 up to and including max_count.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return $clog2(max_count + 1);
   endfunction

   localparam int unsigned INFLIGHT_W = cnt_width(MAX_MUL_INFLIGHT);

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/cpu_mul_scoreboard.sv
// Tracks in-flight multiply destinations and produces the decode stall.
module cpu_mul_scoreboard
   import cpu_wb_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [REG_IDX_W-1:0]  issue_rd,
   input  logic                  res_valid,
   input  logic [REG_IDX_W-1:0]  res_rd,
   input  logic                  rs_a_valid,
   input  logic [REG_IDX_W-1:0]  rs_a,
   input  logic                  rs_b_valid,
   input  logic [REG_IDX_W-1:0]  rs_b,
   input  logic                  rd_valid,
   input  logic [REG_IDX_W-1:0]  rd,
   output logic                  stall_c,
   output logic [SB_WIDTH-1:0]   pending,
   output logic [INFLIGHT_W-1:0] inflight,
   output logic                  proto_err
);

   logic                  full;
   logic                  accept;
   logic                  dec_ok;
   logic                  proto_hit;
   logic [SB_WIDTH-1:0]   pending_next;
   logic [INFLIGHT_W-1:0] inflight_next;

   // Hazard detection against the current scoreboard; the accept depends on it.
   always_comb begin
      full    = (inflight == INFLIGHT_W'(MAX_MUL_INFLIGHT));
      stall_c = 1'b0;
      if (rs_a_valid && pending[rs_a]) stall_c = 1'b1;
      if (rs_b_valid && pending[rs_b]) stall_c = 1'b1;
      if (rd_valid && pending[rd])     stall_c = 1'b1;
      if (issue_valid && (full || pending[issue_rd])) stall_c = 1'b1;
      accept    = issue_valid && !stall_c;
      dec_ok    = res_valid && (inflight != '0);
      proto_hit = res_valid && (!pending[res_rd] || (inflight == '0));
   end

   // Next scoreboard: completion clears, accept sets, counter saturates at zero.
   always_comb begin
      pending_next  = pending;
      inflight_next = inflight;
      if (res_valid) pending_next[res_rd] = 1'b0;
      if (accept)    pending_next[issue_rd] = 1'b1;
      case ({accept, dec_ok})
         2'b10:   inflight_next = inflight + INFLIGHT_W'(1);
         2'b01:   inflight_next = inflight - INFLIGHT_W'(1);
         default: inflight_next = inflight;
      endcase
   end

   // Scoreboard state and sticky protocol error.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending   <= '0;
         inflight  <= '0;
         proto_err <= 1'b0;
      end else begin
         pending  <= pending_next;
         inflight <= inflight_next;
         if (proto_hit) proto_err <= 1'b1;
      end
   end

endmodule

// File: rtl/cpu_wb_scheduler.sv
// Writeback scheduler: registers ALU/MUL results onto the two bank write ports.
module cpu_wb_scheduler
   import cpu_wb_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alu_res_valid,
   input  logic [REG_IDX_W-1:0]  alu_res_rd,
   input  logic [REG_WIDTH-1:0]  alu_res_data,
   input  logic                  mul_res_valid,
   input  logic [REG_IDX_W-1:0]  mul_res_rd,
   input  logic [REG_WIDTH-1:0]  mul_res_data,
   input  logic                  mul_issue_valid,
   input  logic [REG_IDX_W-1:0]  mul_issue_rd,
   input  logic                  dec_rs_a_valid,
   input  logic [REG_IDX_W-1:0]  dec_rs_a,
   input  logic                  dec_rs_b_valid,
   input  logic [REG_IDX_W-1:0]  dec_rs_b,
   input  logic                  dec_rd_valid,
   input  logic [REG_IDX_W-1:0]  dec_rd,
   output logic                  stall,
   output logic                  write_enable,
   output logic [REG_IDX_W-1:0]  write_reg,
   output logic [REG_WIDTH-1:0]  write_data,
   output logic                  write_enable_mul,
   output logic [REG_IDX_W-1:0]  write_reg_mul,
   output logic [REG_WIDTH-1:0]  write_data_mul,
   output logic [SB_WIDTH-1:0]   pending,
   output logic [INFLIGHT_W-1:0] inflight,
   output logic                  collision_err,
   output logic                  proto_err
);

   wb_req_t alu_req;
   wb_req_t mul_req;
   logic    collision_c;

   // Bundle incoming results; the younger ALU result wins a same-register clash.
   always_comb begin
      alu_req     = '{valid: alu_res_valid, rd: alu_res_rd, data: alu_res_data};
      mul_req     = '{valid: mul_res_valid, rd: mul_res_rd, data: mul_res_data};
      collision_c = alu_res_valid && mul_res_valid && (alu_res_rd == mul_res_rd);
   end

   cpu_mul_scoreboard u_sb (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (mul_issue_valid),
      .issue_rd    (mul_issue_rd),
      .res_valid   (mul_res_valid),
      .res_rd      (mul_res_rd),
      .rs_a_valid  (dec_rs_a_valid),
      .rs_a        (dec_rs_a),
      .rs_b_valid  (dec_rs_b_valid),
      .rs_b        (dec_rs_b),
      .rd_valid    (dec_rd_valid),
      .rd          (dec_rd),
      .stall_c     (stall),
      .pending     (pending),
      .inflight    (inflight),
      .proto_err   (proto_err)
   );

   // Bank write ports, one cycle behind the incoming results.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_enable     <= 1'b0;
         write_reg        <= '0;
         write_data       <= '0;
         write_enable_mul <= 1'b0;
         write_reg_mul    <= '0;
         write_data_mul   <= '0;
         collision_err    <= 1'b0;
      end else begin
         write_enable     <= alu_req.valid;
         write_reg        <= alu_req.rd;
         write_data       <= alu_req.data;
         write_enable_mul <= mul_req.valid && !collision_c;
         write_reg_mul    <= mul_req.rd;
         write_data_mul   <= mul_req.data;
         if (collision_c) collision_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_wb_scheduler.sv
// Directed self-checking bench for cpu_wb_scheduler.
module tb_cpu_wb_scheduler;
   import cpu_wb_pkg::*;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  alu_res_valid;
   logic [REG_IDX_W-1:0]  alu_res_rd;
   logic [REG_WIDTH-1:0]  alu_res_data;
   logic                  mul_res_valid;
   logic [REG_IDX_W-1:0]  mul_res_rd;
   logic [REG_WIDTH-1:0]  mul_res_data;
   logic                  mul_issue_valid;
   logic [REG_IDX_W-1:0]  mul_issue_rd;
   logic                  dec_rs_a_valid;
   logic [REG_IDX_W-1:0]  dec_rs_a;
   logic                  dec_rs_b_valid;
   logic [REG_IDX_W-1:0]  dec_rs_b;
   logic                  dec_rd_valid;
   logic [REG_IDX_W-1:0]  dec_rd;
   logic                  stall;
   logic                  write_enable;
   logic [REG_IDX_W-1:0]  write_reg;
   logic [REG_WIDTH-1:0]  write_data;
   logic                  write_enable_mul;
   logic [REG_IDX_W-1:0]  write_reg_mul;
   logic [REG_WIDTH-1:0]  write_data_mul;
   logic [SB_WIDTH-1:0]   pending;
   logic [INFLIGHT_W-1:0] inflight;
   logic                  collision_err;
   logic                  proto_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   cpu_wb_scheduler dut (
      .clock            (clock),
      .reset            (reset),
      .alu_res_valid    (alu_res_valid),
      .alu_res_rd       (alu_res_rd),
      .alu_res_data     (alu_res_data),
      .mul_res_valid    (mul_res_valid),
      .mul_res_rd       (mul_res_rd),
      .mul_res_data     (mul_res_data),
      .mul_issue_valid  (mul_issue_valid),
      .mul_issue_rd     (mul_issue_rd),
      .dec_rs_a_valid   (dec_rs_a_valid),
      .dec_rs_a         (dec_rs_a),
      .dec_rs_b_valid   (dec_rs_b_valid),
      .dec_rs_b         (dec_rs_b),
      .dec_rd_valid     (dec_rd_valid),
      .dec_rd           (dec_rd),
      .stall            (stall),
      .write_enable     (write_enable),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .write_enable_mul (write_enable_mul),
      .write_reg_mul    (write_reg_mul),
      .write_data_mul   (write_data_mul),
      .pending          (pending),
      .inflight         (inflight),
      .collision_err    (collision_err),
      .proto_err        (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      alu_res_valid = 0; alu_res_rd = '0; alu_res_data = '0;
      mul_res_valid = 0; mul_res_rd = '0; mul_res_data = '0;
      mul_issue_valid = 0; mul_issue_rd = '0;
      dec_rs_a_valid = 0; dec_rs_a = '0;
      dec_rs_b_valid = 0; dec_rs_b = '0;
      dec_rd_valid = 0; dec_rd = '0;
   endtask

   task automatic issue(input logic [REG_IDX_W-1:0] r);
      mul_issue_valid = 1; mul_issue_rd = r;
      tick();
      mul_issue_valid = 0;
   endtask

   task automatic complete(input logic [REG_IDX_W-1:0] r, input logic [31:0] d);
      mul_res_valid = 1; mul_res_rd = r; mul_res_data = d;
      tick();
      mul_res_valid = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      tick(); tick();
      reset = 0;
      #1;
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_we_mul", 32'(write_enable_mul), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_errs", 32'({collision_err, proto_err}), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);

      // ALU result appears on port 0 one cycle later
      alu_res_valid = 1; alu_res_rd = 3'd3; alu_res_data = 32'h55;
      tick();
      alu_res_valid = 0;
      chk("alu_we", 32'(write_enable), 32'd1);
      chk("alu_reg", 32'(write_reg), 32'd3);
      chk("alu_data", write_data, 32'h55);
      chk("alu_mul_idle", 32'(write_enable_mul), 32'd0);
      tick();
      chk("alu_we_drop", 32'(write_enable), 32'd0);

      // RAW stall on a pending multiply
      mul_issue_valid = 1; mul_issue_rd = 3'd2;
      #1 chk("issue2_nostall", 32'(stall), 32'd0);
      tick();
      mul_issue_valid = 0;
      chk("issue2_pending", 32'(pending), 32'h04);
      chk("issue2_inflight", 32'(inflight), 32'd1);
      dec_rs_a_valid = 1; dec_rs_a = 3'd2;
      #1 chk("raw_stall", 32'(stall), 32'd1);
      tick();
      chk("raw_stall_hold", 32'(stall), 32'd1);
      dec_rs_b_valid = 1; dec_rs_b = 3'd2; dec_rs_a_valid = 0;
      #1 chk("raw_stall_b", 32'(stall), 32'd1);
      dec_rs_b_valid = 0; dec_rd_valid = 1; dec_rd = 3'd2;
      #1 chk("waw_stall", 32'(stall), 32'd1);
      dec_rd_valid = 0; dec_rs_a_valid = 1;
      mul_res_valid = 1; mul_res_rd = 3'd2; mul_res_data = 32'd42;
      #1 chk("raw_stall_at_res", 32'(stall), 32'd1);
      tick();
      mul_res_valid = 0;
      chk("mul_we", 32'(write_enable_mul), 32'd1);
      chk("mul_reg", 32'(write_reg_mul), 32'd2);
      chk("mul_data", write_data_mul, 32'd42);
      chk("mul_pending_clr", 32'(pending), 32'd0);
      chk("mul_unstall", 32'(stall), 32'd0);
      chk("mul_inflight0", 32'(inflight), 32'd0);
      dec_rs_a_valid = 0;

      // Capacity: four in flight, fifth stalls and is not accepted
      issue(3'd1); issue(3'd2); issue(3'd3); issue(3'd4);
      chk("cap_inflight4", 32'(inflight), 32'd4);
      chk("cap_pending", 32'(pending), 32'h1E);
      mul_issue_valid = 1; mul_issue_rd = 3'd5;
      #1 chk("cap_stall", 32'(stall), 32'd1);
      tick();
      mul_issue_valid = 0;
      chk("cap_no_accept", 32'(inflight), 32'd4);
      chk("cap_no_pend5", 32'(pending), 32'h1E);
      complete(3'd1, 32'hA1);
      chk("cap_done1_data", write_data_mul, 32'hA1);
      chk("cap_inflight3", 32'(inflight), 32'd3);
      // simultaneous accept and completion keeps the count
      mul_issue_valid = 1; mul_issue_rd = 3'd5;
      mul_res_valid = 1; mul_res_rd = 3'd2; mul_res_data = 32'hA2;
      #1 chk("sim_nostall", 32'(stall), 32'd0);
      tick();
      mul_issue_valid = 0; mul_res_valid = 0;
      chk("sim_inflight", 32'(inflight), 32'd3);
      chk("sim_pending", 32'(pending), 32'h38);
      issue(3'd1);
      chk("refill_inflight4", 32'(inflight), 32'd4);
      chk("refill_pending", 32'(pending), 32'h3A);
      complete(3'd3, 32'h0); complete(3'd4, 32'h0);
      complete(3'd5, 32'h0); complete(3'd1, 32'h0);
      chk("drain_inflight", 32'(inflight), 32'd0);
      chk("drain_pending", 32'(pending), 32'd0);
      chk("drain_proto", 32'(proto_err), 32'd0);

      // Same-register collision: ALU wins, mul port suppressed
      issue(3'd6);
      alu_res_valid = 1; alu_res_rd = 3'd6; alu_res_data = 32'h11;
      mul_res_valid = 1; mul_res_rd = 3'd6; mul_res_data = 32'h22;
      tick();
      alu_res_valid = 0; mul_res_valid = 0;
      chk("col_we", 32'(write_enable), 32'd1);
      chk("col_reg", 32'(write_reg), 32'd6);
      chk("col_data", write_data, 32'h11);
      chk("col_we_mul", 32'(write_enable_mul), 32'd0);
      chk("col_err", 32'(collision_err), 32'd1);
      chk("col_pending", 32'(pending), 32'd0);
      chk("col_inflight", 32'(inflight), 32'd0);
      chk("col_no_proto", 32'(proto_err), 32'd0);
      tick();
      chk("col_err_sticky", 32'(collision_err), 32'd1);

      // Result with nothing pending: write still happens, count stays at 0
      complete(3'd7, 32'h77);
      chk("proto_we", 32'(write_enable_mul), 32'd1);
      chk("proto_reg", 32'(write_reg_mul), 32'd7);
      chk("proto_data", write_data_mul, 32'h77);
      chk("proto_err", 32'(proto_err), 32'd1);
      chk("proto_inflight", 32'(inflight), 32'd0);
      tick();
      chk("proto_sticky", 32'(proto_err), 32'd1);

      // Reset mid-operation discards in-flight multiplies
      issue(3'd1); issue(3'd2); issue(3'd3);
      chk("pre_rst_inflight", 32'(inflight), 32'd3);
      reset = 1;
      tick();
      reset = 0;
      dec_rs_a_valid = 1; dec_rs_a = 3'd1;
      #1;
      chk("mid_rst_pending", 32'(pending), 32'd0);
      chk("mid_rst_inflight", 32'(inflight), 32'd0);
      chk("mid_rst_errs", 32'({collision_err, proto_err}), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_we_mul", 32'(write_enable_mul), 32'd0);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
